// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the select/skid pipeline stages.
package pipe_pkg;

    localparam int MODE_EXPLICIT = 0;
    localparam int MODE_RR       = 1;

    // Bit offset of channel ch inside a flat {ch[N-1], ..., ch[0]} bus.
    function automatic int chan_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/mux_skid_stage_rr_arbiter.sv
// Round-robin channel picker: scans from ptr+1 upward with wrap and
// moves the pointer to the granted channel only when the grant is used.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [SEL_W-1:0] grant,
    output logic             grant_valid
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            idx = SEL_W'((int'(ptr_q) + k) % N);
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid) ptr_d = grant;
    end

    // Reset to N-1 so channel 0 is the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= SEL_W'(N - 1);
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mux_skid_stage.sv
// N-way select (explicit or round-robin) feeding a two-entry registered
// skid stage with a valid/ready handshake on both sides.
module mux_skid_stage
    import pipe_pkg::*;
#(
    parameter  int WIDTH = 5,
    parameter  int N     = 2,
    parameter  int MODE  = 0,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef struct packed {
        logic [SEL_W-1:0] src;
        logic [WIDTH-1:0] data;
    } word_t;

    word_t            main_q, main_d, skid_q, skid_d, acc_word;
    logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
    logic [SEL_W-1:0] ch;
    logic             ch_ok;
    logic             accept;
    logic             out_fire;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            rr_arbiter #(.N(N)) u_arb (
                .clk         (clk),
                .rst_n       (rst_n),
                .req         (in_valid),
                .advance     (accept),
                .grant       (ch),
                .grant_valid (ch_ok)
            );
        end else begin : g_sel
            assign ch = sel;
            // Codes >= N (non power-of-2 N) select nothing.
            always_comb begin
                ch_ok = 1'b0;
                for (int i = 0; i < N; i++)
                    if (sel == SEL_W'(i)) ch_ok = 1'b1;
            end
        end
    endgenerate

    // Ready only looks at the skid flag, so it never combinationally
    // depends on out_ready.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++)
            if (ch_ok && ch == SEL_W'(i) && !skid_v_q && !flush) in_ready[i] = 1'b1;
    end

    always_comb begin
        acc_word = '0;
        for (int i = 0; i < N; i++)
            if (in_ready[i]) begin
                acc_word.data = in_data[chan_lsb(i, WIDTH) +: WIDTH];
                acc_word.src  = SEL_W'(i);
            end
    end

    assign accept   = |(in_ready & in_valid);
    assign out_fire = main_v_q && out_ready;

    always_comb begin
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_fire) begin
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                main_d   = acc_word;
                main_v_d = 1'b1;
            end else begin
                main_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_d   = acc_word;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            main_v_q <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign out_data  = main_q.data;
    assign out_src   = main_q.src;
    assign out_valid = main_v_q;

endmodule

// File: tb/tb_mux_skid_stage.sv
// Bench for mux_skid_stage: explicit-select (N=4 and N=3) and round-robin (N=3) instances.
module tb_mux_skid_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // u0: N=4, MODE0
    logic        f0;   logic [1:0] sel0; logic [19:0] din0;
    logic [3:0]  iv0;  logic [3:0] ir0;  logic [4:0]  od0;
    logic [1:0]  os0;  logic ov0;        logic or0;
    // u1: N=3, MODE1
    logic        f1;   logic [1:0] sel1; logic [14:0] din1;
    logic [2:0]  iv1;  logic [2:0] ir1;  logic [4:0]  od1;
    logic [1:0]  os1;  logic ov1;        logic or1;
    // u2: N=3, MODE0
    logic        f2;   logic [1:0] sel2; logic [14:0] din2;
    logic [2:0]  iv2;  logic [2:0] ir2;  logic [4:0]  od2;
    logic [1:0]  os2;  logic ov2;        logic or2;

    mux_skid_stage #(.WIDTH(5), .N(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(f0), .sel(sel0), .in_data(din0),
        .in_valid(iv0), .in_ready(ir0), .out_data(od0), .out_src(os0),
        .out_valid(ov0), .out_ready(or0));
    mux_skid_stage #(.WIDTH(5), .N(3), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(f1), .sel(sel1), .in_data(din1),
        .in_valid(iv1), .in_ready(ir1), .out_data(od1), .out_src(os1),
        .out_valid(ov1), .out_ready(or1));
    mux_skid_stage #(.WIDTH(5), .N(3), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(f2), .sel(sel2), .in_data(din2),
        .in_valid(iv2), .in_ready(ir2), .out_data(od2), .out_src(os2),
        .out_valid(ov2), .out_ready(or2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Scoreboard for u0: words pushed when driven, popped when they leave.
    typedef struct packed { logic [4:0] d; logic [1:0] s; } exp_t;
    exp_t q0[$];
    exp_t e;

    always @(negedge clk) begin
        if (rst_n && ov0 && or0 && !f0) begin
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL sb_extra: got word %0h src %0d want none", od0, os0);
            end else begin
                e = q0.pop_front();
                chk("sb_data", {27'b0, od0}, {27'b0, e.d});
                chk("sb_src",  {30'b0, os0}, {30'b0, e.s});
            end
        end
    end

    typedef struct { logic [1:0] sel; logic fl; logic [2:0] iv; logic [2:0] rdy; } vec_t;
    vec_t tv[6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_a[4];
        int rr_b[4];
        rr_a = '{0, 1, 2, 0};
        rr_b = '{0, 2, 0, 2};
        tv[0] = '{2'd0, 1'b0, 3'b111, 3'b001};
        tv[1] = '{2'd1, 1'b0, 3'b111, 3'b010};
        tv[2] = '{2'd2, 1'b0, 3'b111, 3'b100};
        tv[3] = '{2'd3, 1'b0, 3'b111, 3'b000};
        tv[4] = '{2'd1, 1'b1, 3'b111, 3'b000};
        tv[5] = '{2'd2, 1'b0, 3'b000, 3'b100};

        f0 = 0; sel0 = 2; din0 = {4{5'h1f}}; iv0 = 0; or0 = 0;
        f1 = 0; sel1 = 0; din1 = {5'h12, 5'h11, 5'h10}; iv1 = 0; or1 = 0;
        f2 = 0; sel2 = 3; din2 = {5'h07, 5'h06, 5'h05}; iv2 = 0; or2 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        @(negedge clk);
        chk("rst_ov0", {31'b0, ov0}, 0);
        chk("rst_od0", {27'b0, od0}, 0);
        chk("rst_os0", {30'b0, os0}, 0);
        chk("rst_ir0", {28'b0, ir0}, 32'b0100);
        chk("rst_ir1", {29'b0, ir1}, 0);
        chk("rst_ov1", {31'b0, ov1}, 0);

        // Invalid select on N=3
        for (int k = 0; k < 3; k++) begin
            tick(); iv2 = 3'b111;
            @(negedge clk);
            chk("badsel_rdy", {29'b0, ir2}, 0);
            chk("badsel_ov",  {31'b0, ov2}, 0);
        end

        // Table: in_ready vs sel / flush / in_valid
        or2 = 1;
        for (int k = 0; k < 6; k++) begin
            tick(); sel2 = tv[k].sel; f2 = tv[k].fl; iv2 = tv[k].iv;
            @(negedge clk);
            chk("tbl_rdy", {29'b0, ir2}, {29'b0, tv[k].rdy});
        end
        tick(); iv2 = 0; f2 = 0;

        // MODE0 stream on ch2
        or0 = 1; sel0 = 2;
        din0[10 +: 5] = 5'h11; iv0 = 4'b0100; q0.push_back('{5'h11, 2'd2});
        @(negedge clk);
        chk("str_lat", {31'b0, ov0}, 0);
        tick(); din0[10 +: 5] = 5'h12; q0.push_back('{5'h12, 2'd2});
        @(negedge clk);
        chk("str_ov",  {31'b0, ov0}, 1);
        chk("str_d0",  {27'b0, od0}, 32'h11);
        chk("str_src", {30'b0, os0}, 2);
        tick(); din0[10 +: 5] = 5'h13; q0.push_back('{5'h13, 2'd2});
        @(negedge clk);
        chk("str_d1", {27'b0, od0}, 32'h12);
        tick(); iv0 = 0;
        @(negedge clk);
        chk("str_d2", {27'b0, od0}, 32'h13);
        tick();
        @(negedge clk);
        chk("str_end", {31'b0, ov0}, 0);

        // Stall / skid on ch0
        tick(); or0 = 0; sel0 = 0; din0[4:0] = 5'h0a; iv0 = 4'b0001;
        q0.push_back('{5'h0a, 2'd0});
        tick(); din0[4:0] = 5'h0b; q0.push_back('{5'h0b, 2'd0});
        @(negedge clk);
        chk("stl_a",    {27'b0, od0}, 32'h0a);
        chk("stl_rdy1", {31'b0, ir0[0]}, 1);
        tick(); din0[4:0] = 5'h0c; q0.push_back('{5'h0c, 2'd0});
        @(negedge clk);
        chk("stl_full", {28'b0, ir0}, 0);
        chk("stl_hold", {27'b0, od0}, 32'h0a);
        tick(); or0 = 1;
        @(negedge clk);
        chk("stl_hold3", {27'b0, od0}, 32'h0a);
        tick();
        @(negedge clk);
        chk("stl_b", {27'b0, od0}, 32'h0b);
        tick(); iv0 = 0;
        @(negedge clk);
        chk("stl_c", {27'b0, od0}, 32'h0c);
        tick();
        @(negedge clk);
        chk("stl_end",  {31'b0, ov0}, 0);
        chk("sb_drain", q0.size(), 0);

        // Asynchronous reset with both registers full
        tick(); or0 = 0; sel0 = 2; din0[10 +: 5] = 5'h15; iv0 = 4'b0100;
        tick();
        tick(); iv0 = 0;
        @(negedge clk);
        chk("rstm_full", {31'b0, ov0}, 1);
        chk("rstm_rdy",  {28'b0, ir0}, 0);
        #1 rst_n = 0;
        #1 chk("rstm_async", {31'b0, ov0}, 0);
        q0.delete();
        tick(); rst_n = 1;
        @(negedge clk);
        chk("rstm_rdy2", {28'b0, ir0}, 32'b0100);
        chk("rstm_ov",   {31'b0, ov0}, 0);

        // Round-robin, all valid
        tick(); or1 = 1; iv1 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick(); if (k == 3) iv1 = 0;
            @(negedge clk);
            chk("rr_all_src", {30'b0, os1}, rr_a[k]);
            chk("rr_all_dat", {27'b0, od1}, 32'h10 + rr_a[k]);
        end
        @(negedge clk); #1 rst_n = 0;
        tick(); rst_n = 1;

        // Round-robin, channels 0 and 2
        tick(); iv1 = 3'b101;
        for (int k = 0; k < 4; k++) begin
            tick(); if (k == 3) iv1 = 0;
            @(negedge clk);
            chk("rr_101_src", {30'b0, os1}, rr_b[k]);
        end
        @(negedge clk); #1 rst_n = 0;
        tick(); rst_n = 1;

        // Flush with both full; pointer must survive
        tick(); or1 = 0; iv1 = 3'b111;
        tick();
        tick(); iv1 = 0; f1 = 1; or1 = 1;
        @(negedge clk);
        chk("fl_full", {31'b0, ov1}, 1);
        chk("fl_rdy",  {29'b0, ir1}, 0);
        tick(); f1 = 0; iv1 = 3'b111;
        @(negedge clk);
        chk("fl_ov",  {31'b0, ov1}, 0);
        chk("fl_src", {30'b0, os1}, 0);
        chk("fl_dat", {27'b0, od1}, 32'h10);
        tick(); iv1 = 0;
        @(negedge clk);
        chk("fl_ptr", {30'b0, os1}, 2);
        chk("fl_ov2", {31'b0, ov1}, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
